// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration plus IDLE/SETUP/ACCESS sequencing
// onto a single APB slave port without PREADY.
module apb_master_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 1
) (
    input  logic              SYSCLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WR0,
    input  logic              WR1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              DONE0,
    output logic              DONE1,
    output logic [DATA_W-1:0] RDATA0,
    output logic [DATA_W-1:0] RDATA1,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t              state_q;
    logic                owner_q;
    logic                last_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    logic                sel_c;
    logic                launch_c;
    logic                sel_wr_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;

    // In ACCESS only the non-owner may be launched; the owner's REQ is ignored there.
    always_comb begin
        sel_c    = 1'b0;
        launch_c = 1'b0;
        if (state_q == ST_ACCESS) begin
            sel_c    = ~owner_q;
            launch_c = owner_q ? REQ0 : REQ1;
        end else if (state_q == ST_IDLE) begin
            sel_c    = (REQ0 & REQ1) ? ~last_q : REQ1;
            launch_c = REQ0 | REQ1;
        end
        sel_wr_c    = sel_c ? WR1    : WR0;
        sel_addr_c  = sel_c ? ADDR1  : ADDR0;
        sel_wdata_c = sel_c ? WDATA1 : WDATA0;
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            if (launch_c) begin
                owner_q  <= sel_c;
                pwrite_q <= sel_wr_c;
                paddr_q  <= sel_addr_c;
                pwdata_q <= sel_wr_c ? sel_wdata_c : '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (launch_c) begin
                        psel_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!pwrite_q) begin
                        if (owner_q) rdata1_q <= PRDATA;
                        else         rdata0_q <= PRDATA;
                    end
                    last_q    <= owner_q;
                    penable_q <= 1'b0;
                    if (launch_c) begin
                        state_q <= ST_SETUP;
                    end else begin
                        psel_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign DONE0   = (state_q == ST_ACCESS) & ~owner_q;
    assign DONE1   = (state_q == ST_ACCESS) &  owner_q;
    assign RDATA0  = rdata0_q;
    assign RDATA1  = rdata1_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed and randomized checks of apb_master_arbiter against a transfer-schedule model.
module tb_apb_master_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 1;

    logic              SYSCLK;
    logic              RST;
    logic              REQ0, REQ1, WR0, WR1;
    logic [ADDR_W-1:0] ADDR0, ADDR1, PADDR;
    logic [DATA_W-1:0] WDATA0, WDATA1, RDATA0, RDATA1, PWDATA, PRDATA;
    logic              DONE0, DONE1, PSEL, PENABLE, PWRITE;

    int n_pass = 0;
    int n_chk  = 0;

    apb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .SYSCLK (SYSCLK),
        .RST    (RST),
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .WR0    (WR0),
        .WR1    (WR1),
        .ADDR0  (ADDR0),
        .ADDR1  (ADDR1),
        .WDATA0 (WDATA0),
        .WDATA1 (WDATA1),
        .DONE0  (DONE0),
        .DONE1  (DONE1),
        .RDATA0 (RDATA0),
        .RDATA1 (RDATA1),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic cyc();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: one transfer = setup cycle + access cycle (m_slot 1, 2); 0 = bus free.
    int                m_slot;
    int                m_owner;
    int                m_last;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wd;
    logic [DATA_W-1:0] m_rd [2];

    bit                req_v [2];
    logic              wr_v  [2];
    logic [ADDR_W-1:0] addr_v[2];
    logic [DATA_W-1:0] wd_v  [2];

    function automatic int pick(bit r0, bit r1, int last);
        if (r0 && r1) return 1 - last;
        return r1 ? 1 : 0;
    endfunction

    task automatic model_take(input int o);
        m_owner = o;
        m_wr    = wr_v[o];
        m_addr  = addr_v[o];
        m_wd    = wr_v[o] ? wd_v[o] : '0;
        m_slot  = 1;
    endtask

    task automatic new_cmd(input int x);
        wr_v[x]   = 1'($urandom);
        addr_v[x] = ADDR_W'($urandom);
        wd_v[x]   = DATA_W'($urandom);
    endtask

    initial begin
        bit rst_v;
        RST = 1'b1; REQ0 = 1'b1; REQ1 = 1'b0;
        WR0 = 1'b1; WR1 = 1'b0; ADDR0 = 5'h0A; ADDR1 = '0;
        WDATA0 = 1'b1; WDATA1 = '0; PRDATA = '0;

        // Reset held two cycles with REQ0 high
        cyc(); cyc();
        chk("rst_psel",    32'(PSEL),    0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite",  32'(PWRITE),  0);
        chk("rst_paddr",   32'(PADDR),   0);
        chk("rst_pwdata",  32'(PWDATA),  0);
        chk("rst_rdata0",  32'(RDATA0),  0);
        chk("rst_rdata1",  32'(RDATA1),  0);
        chk("rst_done0",   32'(DONE0),   0);
        chk("rst_done1",   32'(DONE1),   0);
        RST = 1'b0;

        // Single write by requester 0
        cyc();
        chk("wr_setup_psel",    32'(PSEL),    1);
        chk("wr_setup_penable", 32'(PENABLE), 0);
        chk("wr_setup_paddr",   32'(PADDR),   32'h0A);
        chk("wr_setup_pwdata",  32'(PWDATA),  1);
        chk("wr_setup_pwrite",  32'(PWRITE),  1);
        chk("wr_setup_done0",   32'(DONE0),   0);
        cyc();
        chk("wr_acc_penable", 32'(PENABLE), 1);
        chk("wr_acc_done0",   32'(DONE0),   1);
        chk("wr_acc_done1",   32'(DONE1),   0);
        REQ0 = 1'b0;
        cyc();
        chk("wr_end_psel",    32'(PSEL),    0);
        chk("wr_end_penable", 32'(PENABLE), 0);
        chk("wr_end_done0",   32'(DONE0),   0);
        chk("wr_end_paddr",   32'(PADDR),   32'h0A);

        // Single read by requester 1
        REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 5'h03; WDATA1 = 1'b1;
        cyc();
        chk("rd_setup_psel",   32'(PSEL),   1);
        chk("rd_setup_paddr",  32'(PADDR),  32'h03);
        chk("rd_setup_pwrite", 32'(PWRITE), 0);
        chk("rd_setup_pwdata", 32'(PWDATA), 0);
        cyc();
        chk("rd_acc_done1", 32'(DONE1), 1);
        chk("rd_acc_done0", 32'(DONE0), 0);
        PRDATA = 1'b1; REQ1 = 1'b0;
        cyc();
        chk("rd_rdata1", 32'(RDATA1), 1);
        chk("rd_rdata0", 32'(RDATA0), 0);
        chk("rd_psel",   32'(PSEL),   0);
        PRDATA = '0;

        // Tie after reset: grant order 0,1,0,1 with PSEL continuously high
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("tie_rst_rdata1", 32'(RDATA1), 0);
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 5'h11; WDATA0 = 1'b1;
        REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 5'h12;
        PRDATA = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("tie_psel",    32'(PSEL),    1);
            chk("tie_penable", 32'(PENABLE), 32'(i % 2 == 0));
            chk("tie_done0",   32'(DONE0),   32'(i == 2 || i == 6));
            chk("tie_done1",   32'(DONE1),   32'(i == 4 || i == 8));
            chk("tie_paddr",   32'(PADDR),   (((i - 1) / 2) % 2 == 0) ? 32'h11 : 32'h12);
            if (i == 8) begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
        end
        cyc();
        chk("tie_end_psel",   32'(PSEL),   0);
        chk("tie_end_rdata1", 32'(RDATA1), 1);
        chk("tie_end_rdata0", 32'(RDATA0), 0);
        PRDATA = '0;

        // Single requester held: one transfer every 3 cycles
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 5'h07; WDATA0 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk("cont_psel",  32'(PSEL),  32'(i % 3 != 0));
            chk("cont_done0", 32'(DONE0), 32'(i % 3 == 2));
            chk("cont_done1", 32'(DONE1), 0);
            if (i == 8) REQ0 = 1'b0;
        end
        chk("cont_rdata1", 32'(RDATA1), 1);

        // Reset during the ACCESS cycle of a read
        REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 5'h1F;
        cyc();
        chk("rsta_setup_psel", 32'(PSEL), 1);
        cyc();
        chk("rsta_acc_done1", 32'(DONE1), 1);
        RST = 1'b1; PRDATA = 1'b1; REQ1 = 1'b0;
        cyc();
        chk("rsta_psel",    32'(PSEL),    0);
        chk("rsta_penable", 32'(PENABLE), 0);
        chk("rsta_rdata1",  32'(RDATA1),  0);
        chk("rsta_done1",   32'(DONE1),   0);
        chk("rsta_paddr",   32'(PADDR),   0);
        RST = 1'b0; PRDATA = '0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rsta_quiet_done", 32'({DONE1, DONE0}), 0);
            chk("rsta_quiet_psel", 32'(PSEL), 0);
        end

        // Randomized traffic against the model, starting from reset-equivalent state
        m_slot = 0; m_owner = 0; m_last = 1;
        m_wr = 1'b0; m_addr = '0; m_wd = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        for (int x = 0; x < 2; x++) begin
            req_v[x] = 1'b0;
            new_cmd(x);
        end
        for (int k = 0; k < 800; k++) begin
            chk("rnd_psel",    32'(PSEL),    32'(m_slot != 0));
            chk("rnd_penable", 32'(PENABLE), 32'(m_slot == 2));
            chk("rnd_done0",   32'(DONE0),   32'(m_slot == 2 && m_owner == 0));
            chk("rnd_done1",   32'(DONE1),   32'(m_slot == 2 && m_owner == 1));
            chk("rnd_paddr",   32'(PADDR),   32'(m_addr));
            chk("rnd_pwrite",  32'(PWRITE),  32'(m_wr));
            chk("rnd_pwdata",  32'(PWDATA),  32'(m_wd));
            chk("rnd_rdata0",  32'(RDATA0),  32'(m_rd[0]));
            chk("rnd_rdata1",  32'(RDATA1),  32'(m_rd[1]));

            rst_v  = ($urandom_range(0, 99) == 0);
            PRDATA = DATA_W'($urandom);
            for (int x = 0; x < 2; x++) begin
                if (req_v[x]) begin
                    if (!rst_v && m_slot == 2 && m_owner == x) begin
                        req_v[x] = ($urandom_range(0, 1) == 1);
                        new_cmd(x);
                    end
                end else if ($urandom_range(0, 9) < 3) begin
                    req_v[x] = 1'b1;
                    new_cmd(x);
                end
            end
            RST = rst_v;
            REQ0 = req_v[0]; WR0 = wr_v[0]; ADDR0 = addr_v[0]; WDATA0 = wd_v[0];
            REQ1 = req_v[1]; WR1 = wr_v[1]; ADDR1 = addr_v[1]; WDATA1 = wd_v[1];

            if (rst_v) begin
                m_slot = 0; m_owner = 0; m_last = 1;
                m_wr = 1'b0; m_addr = '0; m_wd = '0;
                m_rd[0] = '0; m_rd[1] = '0;
            end else if (m_slot == 0) begin
                if (req_v[0] || req_v[1]) model_take(pick(req_v[0], req_v[1], m_last));
            end else if (m_slot == 1) begin
                m_slot = 2;
            end else begin
                if (!m_wr) m_rd[m_owner] = PRDATA;
                m_last = m_owner;
                if (req_v[1 - m_owner]) model_take(1 - m_owner);
                else m_slot = 0;
            end
            cyc();
        end
        RST = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
